// File: rtl/bp_fe_bp_ghist_hashed.sv
// Global-history branch direction predictor. It indexes a table of saturating counters with a
// gselect or gshare hash and keeps a speculative history that can be restored on redirect.
module bp_fe_bp_ghist_hashed #(
    parameter int bht_idx_width_p   = 8,
    parameter int bp_cnt_sat_bits_p = 2,
    parameter int ghist_width_p     = 6,
    parameter int hash_mode_p       = 0
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    output logic                       init_done_o,

    input  logic                       r_v_i,
    input  logic [bht_idx_width_p-1:0] pc_r_i,
    output logic                       pred_v_o,
    output logic                       predict_o,
    output logic [ghist_width_p-1:0]   ghist_r_o,

    input  logic                       w_v_i,
    input  logic [bht_idx_width_p-1:0] pc_w_i,
    input  logic [ghist_width_p-1:0]   ghist_w_i,
    input  logic                       taken_i,
    input  logic                       redirect_i
);

    localparam int els_lp = 2**bht_idx_width_p;
    localparam logic [bp_cnt_sat_bits_p-1:0] cnt_init_lp =
        bp_cnt_sat_bits_p'((2**(bp_cnt_sat_bits_p-1)) - 1);
    localparam logic [bp_cnt_sat_bits_p-1:0] cnt_max_lp = '1;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_e;

    state_e                      r_state;
    logic [bht_idx_width_p-1:0]  r_sweep;
    logic [ghist_width_p-1:0]    r_spec_ghist;
    logic                        r_init_done;
    logic                        r_pred_v;
    logic                        r_predict;
    logic [ghist_width_p-1:0]    r_ghist_r;

    // NOTE: the counter table has no reset; the post-reset sweep initialises it instead.
    logic [bp_cnt_sat_bits_p-1:0] r_bht [els_lp];

    logic [bht_idx_width_p-1:0]   w_r_idx;
    logic [bht_idx_width_p-1:0]   w_w_idx;
    logic                         w_pred;
    logic [bp_cnt_sat_bits_p-1:0] w_w_cnt;
    logic [bp_cnt_sat_bits_p-1:0] w_w_cnt_nxt;

    if (bp_cnt_sat_bits_p < 1 || ghist_width_p < 2) begin : g_bad_width
        $error("bp_fe_bp_ghist_hashed: counter width must be >= 1 and history width >= 2");
    end

    if (hash_mode_p == 0) begin : g_gselect
        if (ghist_width_p >= bht_idx_width_p) begin : g_bad
            $error("bp_fe_bp_ghist_hashed: gselect needs ghist_width_p < bht_idx_width_p");
        end else begin : g_ok
            assign w_r_idx = {pc_r_i[bht_idx_width_p-ghist_width_p-1:0], r_spec_ghist};
            assign w_w_idx = {pc_w_i[bht_idx_width_p-ghist_width_p-1:0], ghist_w_i};
        end
    end else if (hash_mode_p == 1) begin : g_gshare
        if (ghist_width_p > bht_idx_width_p) begin : g_bad
            $error("bp_fe_bp_ghist_hashed: gshare needs ghist_width_p <= bht_idx_width_p");
        end else begin : g_ok
            assign w_r_idx = pc_r_i ^ bht_idx_width_p'(r_spec_ghist);
            assign w_w_idx = pc_w_i ^ bht_idx_width_p'(ghist_w_i);
        end
    end else begin : g_bad_mode
        $error("bp_fe_bp_ghist_hashed: hash_mode_p must be 0 or 1");
    end

    // The read samples the table before this edge's update, so a same-index write is invisible.
    assign w_pred  = r_bht[w_r_idx][bp_cnt_sat_bits_p-1];
    assign w_w_cnt = r_bht[w_w_idx];

    // NOTE: give every combinational output a default first so no path can infer a latch.
    always_comb begin
        w_w_cnt_nxt = w_w_cnt;
        if (taken_i) begin
            if (w_w_cnt != cnt_max_lp) w_w_cnt_nxt = w_w_cnt + bp_cnt_sat_bits_p'(1);
        end else begin
            if (w_w_cnt != '0) w_w_cnt_nxt = w_w_cnt - bp_cnt_sat_bits_p'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (r_state == ST_INIT) begin
                r_bht[r_sweep] <= cnt_init_lp;
            end else if (w_v_i) begin
                r_bht[w_w_idx] <= w_w_cnt_nxt;
            end
        end
    end

    // NOTE: state is assigned with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= ST_INIT;
            r_sweep      <= '0;
            r_spec_ghist <= '0;
            r_init_done  <= 1'b0;
            r_pred_v     <= 1'b0;
            r_predict    <= 1'b0;
            r_ghist_r    <= '0;
        end else begin
            r_pred_v  <= 1'b0;
            r_predict <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    r_sweep <= r_sweep + bht_idx_width_p'(1);
                    if (r_sweep == '1) begin
                        r_state     <= ST_READY;
                        r_init_done <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (r_v_i) begin
                        r_pred_v     <= 1'b1;
                        r_predict    <= w_pred;
                        r_ghist_r    <= r_spec_ghist;
                        r_spec_ghist <= {r_spec_ghist[ghist_width_p-2:0], w_pred};
                    end
                    // A restore wins over the speculative shift of a same-cycle read.
                    if (w_v_i && redirect_i) begin
                        r_spec_ghist <= {ghist_w_i[ghist_width_p-2:0], taken_i};
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign init_done_o = r_init_done;
    assign pred_v_o    = r_pred_v;
    assign predict_o   = r_predict;
    assign ghist_r_o   = r_ghist_r;

endmodule

// File: tb/tb_bp_fe_bp_ghist_hashed.sv
// Self-checking bench for bp_fe_bp_ghist_hashed. It runs a gselect and a gshare instance side by side
// and compares both against a table/array reference model.
module tb_bp_fe_bp_ghist_hashed;

    localparam int B   = 8;
    localparam int C   = 2;
    localparam int G   = 6;
    localparam int ELS = 1 << B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         r_v;
    logic [B-1:0] pc_r;
    logic         w_v;
    logic [B-1:0] pc_w;
    logic [G-1:0] ghw;
    logic         taken;
    logic         redirect;

    logic [1:0]        init_done;
    logic [1:0]        pred_v;
    logic [1:0]        predict;
    logic [1:0][G-1:0] ghist_r;

    bp_fe_bp_ghist_hashed #(
        .bht_idx_width_p(B), .bp_cnt_sat_bits_p(C), .ghist_width_p(G), .hash_mode_p(0)
    ) u_dut0 (
        .clk_i(clk), .reset_i(reset), .init_done_o(init_done[0]),
        .r_v_i(r_v), .pc_r_i(pc_r), .pred_v_o(pred_v[0]), .predict_o(predict[0]),
        .ghist_r_o(ghist_r[0]), .w_v_i(w_v), .pc_w_i(pc_w), .ghist_w_i(ghw),
        .taken_i(taken), .redirect_i(redirect)
    );

    bp_fe_bp_ghist_hashed #(
        .bht_idx_width_p(B), .bp_cnt_sat_bits_p(C), .ghist_width_p(G), .hash_mode_p(1)
    ) u_dut1 (
        .clk_i(clk), .reset_i(reset), .init_done_o(init_done[1]),
        .r_v_i(r_v), .pc_r_i(pc_r), .pred_v_o(pred_v[1]), .predict_o(predict[1]),
        .ghist_r_o(ghist_r[1]), .w_v_i(w_v), .pc_w_i(pc_w), .ghist_w_i(ghw),
        .taken_i(taken), .redirect_i(redirect)
    );

    // Reference model: counters as plain integers, one table and history per hash mode.
    int tbl [2][ELS];
    int spec [2];
    int sweep;
    bit m_ready;
    bit e_v [2];
    bit e_p [2];
    int e_gh [2];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int hidx(int m, int pc, int h);
        if (m == 0) return ((pc % (1 << (B - G))) << G) | h;
        return (pc ^ h) % ELS;
    endfunction

    task automatic model_step();
        int nspec;
        int idx;
        int cnt;
        if (reset) begin
            sweep   = 0;
            m_ready = 1'b0;
            for (int m = 0; m < 2; m++) begin
                spec[m] = 0; e_v[m] = 1'b0; e_p[m] = 1'b0; e_gh[m] = 0;
            end
            return;
        end
        if (!m_ready) begin
            for (int m = 0; m < 2; m++) begin
                e_v[m] = 1'b0; e_p[m] = 1'b0;
            end
            sweep++;
            if (sweep == ELS) begin
                m_ready = 1'b1;
                for (int m = 0; m < 2; m++)
                    for (int i = 0; i < ELS; i++) tbl[m][i] = (1 << (C - 1)) - 1;
            end
            return;
        end
        for (int m = 0; m < 2; m++) begin
            nspec = spec[m];
            if (r_v) begin
                idx     = hidx(m, int'(pc_r), spec[m]);
                e_v[m]  = 1'b1;
                e_p[m]  = (tbl[m][idx] >= (1 << (C - 1)));
                e_gh[m] = spec[m];
                nspec   = ((spec[m] << 1) | int'(e_p[m])) % (1 << G);
            end else begin
                e_v[m] = 1'b0;
                e_p[m] = 1'b0;
            end
            if (w_v) begin
                idx = hidx(m, int'(pc_w), int'(ghw));
                cnt = tbl[m][idx];
                if (taken) cnt = (cnt + 1 > (1 << C) - 1) ? (1 << C) - 1 : cnt + 1;
                else       cnt = (cnt - 1 < 0) ? 0 : cnt - 1;
                tbl[m][idx] = cnt;
                if (redirect) nspec = ((int'(ghw) << 1) | int'(taken)) % (1 << G);
            end
            spec[m] = nspec;
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            check($sformatf("m%0d init_done", m), 32'(init_done[m]), 32'(m_ready));
            check($sformatf("m%0d pred_v", m),    32'(pred_v[m]),    32'(e_v[m]));
            check($sformatf("m%0d predict", m),   32'(predict[m]),   32'(e_p[m]));
            check($sformatf("m%0d ghist_r", m),   32'(ghist_r[m]),   32'(e_gh[m]));
        end
    endtask

    task automatic idle();
        r_v = 1'b0; w_v = 1'b0; redirect = 1'b0; taken = 1'b0;
    endtask

    task automatic do_read(input logic [B-1:0] pc);
        idle();
        r_v = 1'b1; pc_r = pc;
        step();
    endtask

    task automatic do_write(input logic [B-1:0] pc, input logic [G-1:0] gh,
                            input logic t, input logic rd);
        idle();
        w_v = 1'b1; pc_w = pc; ghw = gh; taken = t; redirect = rd;
        step();
    endtask

    task automatic set_spec(input logic [G-1:0] val, input logic [B-1:0] pc);
        logic [G-1:0] v;
        v = val;
        do_write(pc, v >> 1, v[0], 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        pc_r = '0; pc_w = '0; ghw = '0;

        for (int i = 0; i < 3; i++) step();
        check("reset ghist_r", 32'(ghist_r[0]), 32'd0);
        check("reset init_done", 32'(init_done), 32'd0);

        // Requests during the sweep must be ignored; then reset again at sweep 100.
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            r_v = 1'b1; pc_r = B'($urandom); w_v = 1'b1; pc_w = B'($urandom);
            taken = 1'b1; redirect = 1'b1; ghw = G'($urandom);
            step();
        end
        reset = 1'b1;
        idle();
        step();
        reset = 1'b0;
        for (int i = 0; i < ELS - 1; i++) step();
        check("init_done one cycle early", 32'(init_done), 32'd0);
        step();
        check("init_done after sweep", 32'(init_done), 32'd3);

        do_read(8'h33);
        check("first read not taken", 32'(predict[0]), 32'd0);

        for (int i = 0; i < 3; i++) do_write(8'h05, 6'd0, 1'b1, 1'b0);
        do_read(8'h05);
        check("trained taken", 32'(predict), 32'd3);
        for (int i = 0; i < 5; i++) do_write(8'h05, 6'd0, 1'b0, 1'b0);
        set_spec(6'd0, 8'h05);
        do_read(8'h05);
        check("trained not taken", 32'(predict[0]), 32'd0);

        set_spec(6'd0, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            idle();
            r_v = 1'b1; pc_r = B'(8'h10 + i);
            step();
            check($sformatf("b2b ghist_r %0d", i), 32'(ghist_r[0]), 32'd0);
            check($sformatf("b2b pred_v %0d", i), 32'(pred_v), 32'd3);
        end
        do_write(8'h10, 6'd0, 1'b1, 1'b0);
        set_spec(6'd0, 8'hFF);
        do_read(8'h10);
        do_read(8'h11);
        check("spec shifted by taken", 32'(ghist_r[0]), 32'd1);

        idle();
        r_v = 1'b1; pc_r = 8'h22;
        w_v = 1'b1; pc_w = 8'h22; ghw = 6'b101010; taken = 1'b1; redirect = 1'b1;
        step();
        do_read(8'h01);
        check("redirect restore m0", 32'(ghist_r[0]), 32'b010101);
        check("redirect restore m1", 32'(ghist_r[1]), 32'b010101);

        set_spec(6'd0, 8'h99);
        idle();
        r_v = 1'b1; pc_r = 8'h02;
        w_v = 1'b1; pc_w = 8'h02; ghw = 6'd0; taken = 1'b1;
        step();
        check("read before write", 32'(predict[0]), 32'd0);
        do_read(8'h02);
        check("write not lost", 32'(predict), 32'd3);

        set_spec(6'b111100, 8'h99);
        do_read(8'h3C);
        check("xor alias before", 32'(predict[1]), 32'd0);
        do_write(8'h00, 6'd0, 1'b1, 1'b0);
        set_spec(6'b111100, 8'h99);
        do_read(8'h3C);
        check("xor alias after", 32'(predict[1]), 32'd1);

        // Random traffic with a narrow PC range for frequent aliasing, plus one mid-run reset.
        for (int i = 0; i < 2000; i++) begin
            reset    = (i == 1000 || i == 1001);
            r_v      = 1'($urandom);
            pc_r     = B'($urandom_range(0, 31));
            w_v      = 1'($urandom);
            pc_w     = B'($urandom_range(0, 31));
            ghw      = G'($urandom);
            taken    = 1'($urandom);
            redirect = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
